// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in parallel-out receive path.
package sipo_pkg;

   localparam int SIPO_W_DEFAULT = 3;

   typedef enum logic {
      HOLD_EMPTY,
      HOLD_FULL
   } hold_e;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Parallel output bus of the deserializer: held word plus valid/ready handshake.
interface sipo_deserializer_if #(
   parameter int WIDTH = 3
);
   logic [WIDTH-1:0] pout;
   logic             pvalid;
   logic             pready;

   modport master (output pout, output pvalid, input pready);
   modport slave  (input pout, input pvalid, output pready);
endinterface

// File: rtl/sipo_shift_core.sv
// Bit assembly for the deserializer: shift register, bit counter and flush.
// word_done is a combinational strobe so the holding register loads on the completing edge.
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter  int WIDTH = SIPO_W_DEFAULT,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift,
   input  logic             si,
   input  logic             flush,
   output logic [CW-1:0]    bcnt,
   output logic             word_done,
   output logic [WIDTH-1:0] word_data
);

   logic [WIDTH-1:0] sreg;
   logic             last_bit;
   logic             sreg_lsb_unused;

   assign last_bit  = (bcnt == CW'(WIDTH - 1));
   assign word_done = shift && !flush && last_bit;
   assign word_data = {si, sreg[WIDTH-1:1]};

   // Bit 0 is pushed out by the completing strobe and never reaches the word.
   assign sreg_lsb_unused = sreg[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         bcnt <= '0;
      end else if (flush) begin
         sreg <= '0;
         bcnt <= '0;
      end else if (shift) begin
         sreg <= {si, sreg[WIDTH-1:1]};
         bcnt <= last_bit ? '0 : bcnt + CW'(1);
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: shift core feeding a one-deep holding
// register with valid/ready handshake and sticky overrun flag.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter  int WIDTH = SIPO_W_DEFAULT,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                shift,
   input  logic                si,
   input  logic                flush,
   input  logic                clr_ovr,
   output logic [CW-1:0]       bcnt,
   output logic                busy,
   output logic                overrun,
   sipo_deserializer_if.master pbus
);

   logic             word_done;
   logic [WIDTH-1:0] word_data;
   logic [WIDTH-1:0] pout_q;
   hold_e            hold_q;
   hold_e            hold_nxt;
   logic             load;
   logic             ovr_set;

   sipo_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .rst       (rst),
      .shift     (shift),
      .si        (si),
      .flush     (flush),
      .bcnt      (bcnt),
      .word_done (word_done),
      .word_data (word_data)
   );

   assign busy        = (bcnt != '0);
   assign pbus.pout   = pout_q;
   assign pbus.pvalid = (hold_q == HOLD_FULL);

   always_comb begin
      hold_nxt = hold_q;
      load     = 1'b0;
      ovr_set  = 1'b0;
      case (hold_q)
         HOLD_EMPTY: begin
            if (word_done) begin
               load     = 1'b1;
               hold_nxt = HOLD_FULL;
            end
         end
         HOLD_FULL: begin
            if (pbus.pready) begin
               if (word_done) load = 1'b1;
               else           hold_nxt = HOLD_EMPTY;
            end else if (word_done) begin
               ovr_set = 1'b1;
            end
         end
         default: hold_nxt = HOLD_EMPTY;
      endcase
   end

   // Overrun set takes priority over a same-edge clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q  <= HOLD_EMPTY;
         pout_q  <= '0;
         overrun <= 1'b0;
      end else begin
         hold_q  <= hold_nxt;
         if (load) pout_q <= word_data;
         overrun <= ovr_set || (overrun && !clr_ovr);
      end
   end

endmodule
